// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: bus widths, payload layout, load_op codes and stage states shared by mem_stage.
package mem_stage_pkg;
    localparam int ES_TO_MS_BUS_WD = 76;
    localparam int MS_TO_WS_BUS_WD = 71;
    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_B  = 3'b001;
    localparam logic [2:0] LD_H  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b011;
    localparam logic [2:0] LD_HU = 3'b100;
    typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_READY} state_t;
    typedef struct packed {
        logic        mem_req;
        logic [2:0]  load_op;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
        logic        is_exc;
    } es_bus_t;
endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: picks the addressed byte/half of a load word and sign/zero-extends it.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  load_op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] result
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    assign byte_sel = 8'(rdata >> {addr, 3'b000});
    assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    always_comb
        result = load_op == LD_B  ? {{24{byte_sel[7]}}, byte_sel} :
                 load_op == LD_BU ? {24'b0, byte_sel} :
                 load_op == LD_H  ? {{16{half_sel[15]}}, half_sel} :
                 load_op == LD_HU ? {16'b0, half_sel} : rdata;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage; waits for the data SRAM response, aligns load
// data and presents forwarding info to decode and the write-back bus.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_allowin,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic [4:0]                 ms_to_ds_dest,
    output logic [31:0]                ms_to_ds_result,
    output logic                       ms_to_ds_ld_busy,
    output logic                       ms_to_ds_is_exc
);
    state_t state, state_n;
    es_bus_t in, r;
    logic [31:0] buf_q, load_word, load_res, final_result;
    logic ms_valid, data_ok, ready_go, leave, accept;
    assign in = es_to_ms_bus;
    assign ms_valid = state != S_EMPTY;
    // data_ok only means something while a request is outstanding
    assign data_ok = state == S_WAIT && data_sram_data_ok;
    assign ready_go = state == S_READY || data_ok;
    assign leave = ms_valid && ready_go && ws_allowin;
    assign ms_allowin = !ms_valid || (ready_go && ws_allowin);
    assign accept = es_to_ms_valid && ms_allowin;
    assign ms_to_ws_valid = ms_valid && ready_go;
    always_comb
        state_n = accept ? (in.mem_req ? S_WAIT : S_READY) :
                  leave ? S_EMPTY :
                  data_ok ? S_READY : state;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= S_EMPTY;
            r <= '0;
            buf_q <= '0;
        end else begin
            state <= state_n;
            if (accept) r <= in;
            if (data_ok && !ws_allowin) buf_q <= data_sram_rdata;
        end
    assign load_word = data_ok ? data_sram_rdata : buf_q;
    load_align u_align (
        .load_op(r.load_op),
        .addr   (r.alu_result[1:0]),
        .rdata  (load_word),
        .result (load_res)
    );
    assign final_result = r.res_from_mem ? load_res : r.alu_result;
    assign ms_to_ws_bus = {r.gr_we, r.dest, final_result, r.pc, r.is_exc};
    assign ms_to_ds_dest = (ms_valid && r.gr_we) ? r.dest : 5'd0;
    assign ms_to_ds_result = final_result;
    assign ms_to_ds_ld_busy = state == S_WAIT && r.mem_req && r.res_from_mem && !data_sram_data_ok;
    assign ms_to_ds_is_exc = r.is_exc && ms_valid;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven load/store/ALU vectors plus handshake corner sequences,
// write-back traffic checked against a queue of expected buses.
module tb_mem_stage;
    import mem_stage_pkg::*;
    logic clk = 0;
    logic reset = 1;
    logic es_to_ms_valid = 0;
    logic [75:0] es_to_ms_bus = '0;
    logic ms_allowin, ms_to_ws_valid, ms_to_ds_ld_busy, ms_to_ds_is_exc;
    logic ws_allowin = 1;
    logic [70:0] ms_to_ws_bus;
    logic data_sram_data_ok = 0;
    logic [31:0] data_sram_rdata = '0;
    logic [4:0] ms_to_ds_dest;
    logic [31:0] ms_to_ds_result;
    int total = 0;
    int bad = 0;
    logic [70:0] sbq[$];
    logic pend = 0;
    logic stray_ok = 0;

    mem_stage dut (
        .clk(clk), .reset(reset),
        .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
        .ms_allowin(ms_allowin), .ws_allowin(ws_allowin),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .ms_to_ds_dest(ms_to_ds_dest), .ms_to_ds_result(ms_to_ds_result),
        .ms_to_ds_ld_busy(ms_to_ds_ld_busy), .ms_to_ds_is_exc(ms_to_ds_is_exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [75:0] mk(input logic mreq, input logic [2:0] op, input logic rfm,
        input logic we, input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] pc,
        input logic exc);
        return {mreq, op, rfm, we, dest, alu, pc, exc};
    endfunction

    function automatic logic [70:0] wsb(input logic we, input logic [4:0] dest,
        input logic [31:0] res, input logic [31:0] pc, input logic exc);
        return {we, dest, res, pc, exc};
    endfunction

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    // scoreboard: every write-back handoff must match the oldest pushed expectation
    always @(negedge clk)
        if (!reset && ms_to_ws_valid && ws_allowin) begin
            if (sbq.size() == 0) chk("unexpected_ws", 76'(ms_to_ws_valid), 76'd0);
            else chk("ws_bus", 76'(ms_to_ws_bus), 76'(sbq.pop_front()));
        end

    // protocol watch: data_ok only while the bench has a request outstanding
    always @(negedge clk)
        if (data_sram_data_ok && !pend && !stray_ok)
            chk("stray_data_ok", 76'(data_sram_data_ok), 76'd0);

    typedef struct {
        logic        mreq;
        logic [2:0]  op;
        logic        rfm;
        logic        we;
        logic        exc;
        logic [1:0]  lo;
        logic [31:0] rdata;
        int          dly;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[12];

    task automatic reset_outs(input string tag);
        chk({tag, "_allowin"}, 76'(ms_allowin), 76'd1);
        chk({tag, "_valid"}, 76'(ms_to_ws_valid), 76'd0);
        chk({tag, "_dest"}, 76'(ms_to_ds_dest), 76'd0);
        chk({tag, "_busy"}, 76'(ms_to_ds_ld_busy), 76'd0);
        chk({tag, "_exc"}, 76'(ms_to_ds_is_exc), 76'd0);
        chk({tag, "_bus"}, 76'(ms_to_ws_bus), 76'd0);
        chk({tag, "_result"}, 76'(ms_to_ds_result), 76'd0);
    endtask

    initial begin
        logic [31:0] alu, pc;
        vecs[0]  = '{1, LD_W,   1, 1, 0, 2'd0, 32'h1234_5678, 0, 32'h1234_5678};
        vecs[1]  = '{1, LD_B,   1, 1, 0, 2'd3, 32'h80FF_1234, 1, 32'hFFFF_FF80};
        vecs[2]  = '{1, LD_B,   1, 1, 0, 2'd2, 32'h00AA_0000, 2, 32'hFFFF_FFAA};
        vecs[3]  = '{1, LD_BU,  1, 1, 0, 2'd1, 32'h0000_F000, 0, 32'h0000_00F0};
        vecs[4]  = '{1, LD_H,   1, 1, 0, 2'd2, 32'h9ABC_0000, 1, 32'hFFFF_9ABC};
        vecs[5]  = '{1, LD_H,   1, 1, 0, 2'd0, 32'h0000_7FFF, 0, 32'h0000_7FFF};
        vecs[6]  = '{1, LD_HU,  1, 1, 0, 2'd0, 32'h0000_8765, 0, 32'h0000_8765};
        vecs[7]  = '{1, 3'b111, 1, 1, 0, 2'd0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF};
        vecs[8]  = '{1, LD_W,   0, 0, 0, 2'd0, 32'h5555_5555, 4, 32'h0000_1000};
        vecs[9]  = '{0, LD_W,   0, 1, 0, 2'd1, 32'h0,         0, 32'h0000_1001};
        vecs[10] = '{0, LD_W,   0, 0, 1, 2'd0, 32'h0,         0, 32'h0000_1000};
        vecs[11] = '{1, LD_BU,  1, 1, 0, 2'd3, 32'hC300_0000, 3, 32'h0000_00C3};

        repeat (2) cyc();
        reset_outs("rst");
        reset = 0;

        foreach (vecs[i]) begin
            alu = 32'h0000_1000 | 32'(vecs[i].lo);
            pc = 32'h1C00_0000 + 32'(i * 4);
            cyc();
            es_to_ms_valid = 1;
            es_to_ms_bus = mk(vecs[i].mreq, vecs[i].op, vecs[i].rfm, vecs[i].we, 5'd7, alu, pc, vecs[i].exc);
            sbq.push_back(wsb(vecs[i].we, 5'd7, vecs[i].exp, pc, vecs[i].exc));
            #1 chk($sformatf("v%0d_allowin", i), 76'(ms_allowin), 76'd1);
            cyc();
            es_to_ms_valid = 0;
            if (vecs[i].mreq) begin
                pend = 1;
                for (int k = 0; k < vecs[i].dly; k++) begin
                    data_sram_rdata = $urandom;
                    #1;
                    chk($sformatf("v%0d_wait_valid", i), 76'(ms_to_ws_valid), 76'd0);
                    chk($sformatf("v%0d_busy", i), 76'(ms_to_ds_ld_busy), 76'(vecs[i].rfm));
                    chk($sformatf("v%0d_dest", i), 76'(ms_to_ds_dest), vecs[i].we ? 76'd7 : 76'd0);
                    cyc();
                end
                data_sram_data_ok = 1;
                data_sram_rdata = vecs[i].rdata;
            end
            #1;
            chk($sformatf("v%0d_valid", i), 76'(ms_to_ws_valid), 76'd1);
            chk($sformatf("v%0d_result", i), 76'(ms_to_ds_result), 76'(vecs[i].exp));
            chk($sformatf("v%0d_busy_done", i), 76'(ms_to_ds_ld_busy), 76'd0);
            chk($sformatf("v%0d_exc", i), 76'(ms_to_ds_is_exc), 76'(vecs[i].exc));
            cyc();
            data_sram_data_ok = 0;
            pend = 0;
        end

        // LD_HU with write-back stalled: data captured in buffer, delivered later
        cyc();
        es_to_ms_valid = 1;
        ws_allowin = 0;
        es_to_ms_bus = mk(1, LD_HU, 1, 1, 5'd9, 32'h0000_2002, 32'h1C00_0100, 0);
        sbq.push_back(wsb(1, 5'd9, 32'h0000_8001, 32'h1C00_0100, 0));
        cyc();
        es_to_ms_valid = 0;
        pend = 1;
        data_sram_data_ok = 1;
        data_sram_rdata = 32'h8001_0000;
        #1 chk("hu_ok_allowin", 76'(ms_allowin), 76'd0);
        cyc();
        data_sram_data_ok = 0;
        pend = 0;
        data_sram_rdata = 32'h0BAD_F00D;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hu_hold_allowin", 76'(ms_allowin), 76'd0);
            chk("hu_hold_valid", 76'(ms_to_ws_valid), 76'd1);
            chk("hu_hold_result", 76'(ms_to_ds_result), 76'h8001);
            if (k < 2) cyc();
        end
        cyc();
        ws_allowin = 1;
        #1 chk("hu_release_allowin", 76'(ms_allowin), 76'd1);
        cyc();

        // back-to-back ALU instructions, no bubble
        es_to_ms_valid = 1;
        es_to_ms_bus = mk(0, LD_W, 0, 1, 5'd3, 32'h1, 32'h1C00_0200, 0);
        sbq.push_back(wsb(1, 5'd3, 32'h1, 32'h1C00_0200, 0));
        cyc();
        es_to_ms_bus = mk(0, LD_W, 0, 1, 5'd4, 32'h2, 32'h1C00_0204, 0);
        sbq.push_back(wsb(1, 5'd4, 32'h2, 32'h1C00_0204, 0));
        #1;
        chk("b2b_valid0", 76'(ms_to_ws_valid), 76'd1);
        chk("b2b_dest0", 76'(ms_to_ds_dest), 76'd3);
        chk("b2b_allowin0", 76'(ms_allowin), 76'd1);
        cyc();
        es_to_ms_valid = 0;
        #1;
        chk("b2b_valid1", 76'(ms_to_ws_valid), 76'd1);
        chk("b2b_dest1", 76'(ms_to_ds_dest), 76'd4);
        chk("b2b_result1", 76'(ms_to_ds_result), 76'd2);
        cyc();
        #1 chk("b2b_empty", 76'(ms_to_ws_valid), 76'd0);

        // reset while waiting, then a stray data_ok
        cyc();
        es_to_ms_valid = 1;
        es_to_ms_bus = mk(1, LD_W, 1, 1, 5'd11, 32'h0000_3000, 32'h1C00_0300, 0);
        cyc();
        es_to_ms_valid = 0;
        #1 chk("rw_busy", 76'(ms_to_ds_ld_busy), 76'd1);
        reset = 1;
        #1 reset_outs("rw_rst");
        cyc();
        reset = 0;
        cyc();
        stray_ok = 1;
        data_sram_data_ok = 1;
        data_sram_rdata = 32'hFFFF_FFFF;
        #1 reset_outs("rw_stray");
        cyc();
        data_sram_data_ok = 0;
        stray_ok = 0;
        repeat (2) cyc();

        chk("sb_drain", 76'(sbq.size()), 76'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage LoongArch pipeline, between the execute stage and the write-back stage. It holds one instruction, waits for the data SRAM response when that instruction issued a memory request, and extracts and sign/zero-extends load data. It drives the forwarding/stall information to decode and presents the write-back bus to write-back.

## Interface
Parameters (shared `define`s, no module parameters):
- ES_TO_MS_BUS_WD, 76: {mem_req[75], load_op[74:72], res_from_mem[71], gr_we[70], dest[69:65], alu_result[64:33], pc[32:1], is_exc[0]}
- MS_TO_WS_BUS_WD, 71: {gr_we[70], dest[69:65], final_result[64:33], pc[32:1], is_exc[0]}

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high; one clock, all state cleared immediately on assertion
- es_to_ms_valid  in  1  execute stage holds a valid instruction
- es_to_ms_bus  in  76  instruction payload, layout above
- ms_allowin  out  1  stage can accept a new instruction this cycle
- ws_allowin  in  1  write-back can accept
- ms_to_ws_valid  out  1  valid instruction ready for write-back
- ms_to_ws_bus  out  71  write-back payload
- data_sram_data_ok  in  1  response for the single outstanding request (load data or store ack)
- data_sram_rdata  in  32  load data, valid with data_ok
- ms_to_ds_dest  out  5  destination, zeroed when stage empty or gr_we=0
- ms_to_ds_result  out  32  final_result for forwarding
- ms_to_ds_ld_busy  out  1  valid load whose data is not yet available; decode must stall a dependent instruction
- ms_to_ds_is_exc  out  1  is_exc & ms_valid

## Operation
- load_op: 000 LD_W, 001 LD_B, 010 LD_H, 011 LD_BU, 100 LD_HU; others treated as LD_W.
- Byte select by alu_result[1:0]; LD_H/HU use alu_result[1] (alignment already guaranteed by execute or flagged in is_exc).
- final_result = res_from_mem ? extended load data : alu_result.
- Load data source: live data_sram_rdata in the cycle data_ok arrives, else the 32-bit capture buffer.
- is_exc=1 instructions pass through; gr_we forwarded unchanged (write-back masks nothing extra).
- States:
  - EMPTY: ms_valid=0.
  - WAIT: valid, mem_req=1, no data_ok yet.
  - READY: valid, data available (mem_req=0 or data captured).
- Transitions:
  - On accept (es_to_ms_valid & ms_allowin): -> WAIT if mem_req else READY; payload latched.
  - WAIT & data_ok & ws_allowin: leave; next state from accept or EMPTY.
  - WAIT & data_ok & !ws_allowin: -> READY, rdata into buffer.
  - READY & ws_allowin: leave likewise.
  - Otherwise hold.
- ready_go = READY | (WAIT & data_ok); ms_to_ws_valid = ms_valid & ready_go; ms_allowin = !ms_valid | (ready_go & ws_allowin).
- ms_to_ds_ld_busy = WAIT & res_from_mem & !data_ok.
- data_ok outside WAIT is a protocol violation: ignored, flagged by bench assertion.

## Timing
- Reset values:
  - state EMPTY, payload register and buffer 0.
  - ms_allowin=1, ms_to_ws_valid=0, ms_to_ds_dest=0, ms_to_ds_ld_busy=0, ms_to_ds_is_exc=0.
  - ms_to_ws_bus=0, ms_to_ds_result=0.
- Zero added latency: instruction accepted at edge t, data_ok in cycle t+k -> ms_to_ws_valid in the same cycle t+k, combinational from data_ok.
- Non-memory instruction: ms_to_ws_valid in first cycle after accept.
- Simultaneous leave and accept in one edge: new payload replaces old, no bubble.
- Buffer written only on WAIT&data_ok&!ws_allowin; not cleared on leave.
- Reset asserted while WAIT: entry dropped; any later data_ok is ignored.

## Structure
- Bus widths, field offsets, load_op codes and state encodings go in mycpu.h.
- One optional sub-module, load_align: combinational extractor for (load_op, addr[1:0], rdata) -> 32-bit result.
- Remaining RTL: FSM, payload/buffer registers, handshake, forwarding outputs.

## Test plan
- LD_B, addr[1:0]=3, rdata=0x80FF_1234 with data_ok one cycle after accept, ws_allowin=1 -> final_result 0xFFFF_FF80, ms_to_ws_valid the same cycle, ld_busy high only in prior cycle.
- LD_HU, addr[1]=1, rdata=0x8001_0000, data_ok while ws_allowin=0 for 3 cycles -> state READY, buffered result 0x0000_8001 delivered when ws_allowin rises; ms_allowin=0 throughout.
- Back-to-back ALU instructions, result 0x1 then 0x2 -> two consecutive ms_to_ws_valid cycles, no bubble, dest forwarded each cycle.
- Store (mem_req=1, res_from_mem=0), data_ok delayed 4 cycles -> ld_busy stays 0, ms_to_ws_valid only on the data_ok cycle, final_result = alu_result.
- is_exc=1, mem_req=0 -> passes in one cycle, ms_to_ds_is_exc=1 and bus bit0=1.
- Reset asserted mid-WAIT, then stray data_ok -> outputs at reset values, no ms_to_ws_valid.
